// File: rtl/fir_interp_if.sv
// Streaming bus between the interpolator and its two show-ahead FIFOs.
// The input side carries the FIFO pop handshake; the output side the push handshake.
interface fir_interp_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  x_in_rd_en;
  logic                  x_in_empty;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_out_wr_en;
  logic                  y_out_full;

  // Filter side: pops the input FIFO, pushes the output FIFO.
  modport master (
    output x_in_rd_en,
    input  x_in_empty,
    input  x_in,
    output y_out,
    output y_out_wr_en,
    input  y_out_full
  );

  // FIFO / environment side.
  modport slave (
    input  x_in_rd_en,
    output x_in_empty,
    output x_in,
    input  y_out,
    input  y_out_wr_en,
    output y_out_full
  );
endinterface

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: each popped input sample yields INTERP outputs, phase 0 first.
// One multiply-accumulate per cycle over the PH_TAPS history entries of the current phase.
module fir_interp #(
  parameter int unsigned INTERP     = 8,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] coeff = '0
) (
  input logic          clk,
  input logic          rst,
  fir_interp_if.master bus_io
);

  localparam int unsigned PH_TAPS = TAPS / INTERP;
  localparam int unsigned PhW     = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int unsigned TapW    = (PH_TAPS > 1) ? $clog2(PH_TAPS) : 1;
  localparam int unsigned CIdxW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  if (TAPS % INTERP != 0) begin : g_cfg_check
    $error("fir_interp: TAPS must be a multiple of INTERP");
  end

  typedef enum logic [1:0] {StIdle, StMac, StWrite} state_e;

  state_e                        state_q;
  logic [PhW-1:0]                phase_q;
  logic [TapW-1:0]               tap_q;
  logic [DATA_WIDTH-1:0]         acc_q;
  logic [DATA_WIDTH-1:0]         y_out_q;
  logic                          wr_en_q;
  logic signed [DATA_WIDTH-1:0]  hist_q [PH_TAPS];

  logic [CIdxW-1:0]              coeff_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]         mac_term;
  logic [DATA_WIDTH-1:0]         mac_sum;

  // Current MAC term: coeff[phase + tap*INTERP] * hist[tap], dequantized with a flooring shift.
  always_comb begin
    coeff_idx = CIdxW'(phase_q) + CIdxW'(tap_q) * CIdxW'(INTERP);
    prod      = $signed(coeff[coeff_idx]) * hist_q[tap_q];
    mac_term  = DATA_WIDTH'(prod >>> FRAC_BITS);
    mac_sum   = acc_q + mac_term;
  end

  // Pop is combinational so the FIFO head is consumed in the same cycle it is latched.
  assign bus_io.x_in_rd_en  = (state_q == StIdle) && !bus_io.x_in_empty;
  assign bus_io.y_out       = y_out_q;
  assign bus_io.y_out_wr_en = wr_en_q;

  // Control FSM, history shift register, accumulator and registered output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      y_out_q <= '0;
      wr_en_q <= 1'b0;
      for (int unsigned k = 0; k < PH_TAPS; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus_io.x_in_empty) begin
            for (int unsigned k = 1; k < PH_TAPS; k++) begin
              hist_q[k] <= hist_q[k-1];
            end
            hist_q[0] <= $signed(bus_io.x_in);
            phase_q   <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            state_q   <= StMac;
          end
        end
        StMac: begin
          acc_q <= mac_sum;
          if (tap_q == TapW'(PH_TAPS - 1)) begin
            tap_q   <= '0;
            state_q <= StWrite;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        StWrite: begin
          // While full, everything holds so the pending sample is written exactly once.
          if (!bus_io.y_out_full) begin
            y_out_q <= acc_q;
            wr_en_q <= 1'b1;
            acc_q   <= '0;
            if (phase_q == PhW'(INTERP - 1)) begin
              state_q <= StIdle;
            end else begin
              phase_q <= phase_q + 1'b1;
              state_q <= StMac;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Bench for fir_interp: three instances (LPF table, sign/floor table, wrap table) fed from
// bench-side FIFO queues; expected outputs are queued at stimulus time and popped on writes.
module tb_fir_interp;

  localparam logic [0:31][31:0] LPF = {
    -32'sd3,   -32'sd6,   -32'sd12,  -32'sd18,  -32'sd22,  -32'sd23,  -32'sd20,  -32'sd13,
     32'sd21,   32'sd63,   32'sd130,  32'sd221,  32'sd330,  32'sd440,  32'sd530,  32'sd579,
     32'sd579,  32'sd530,  32'sd440,  32'sd330,  32'sd221,  32'sd130,  32'sd63,   32'sd21,
    -32'sd13,  -32'sd20,  -32'sd23,  -32'sd22,  -32'sd18,  -32'sd12,  -32'sd6,   -32'sd3
  };
  localparam logic [0:31][31:0] CSIGN = {32'sd3, {31{32'd0}}};
  localparam logic [0:31][31:0] CWRAP = {32'd2048, {7{32'd0}}, 32'd1024, {23{32'd0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_interp_if #(.DATA_WIDTH(32)) bus_a ();
  fir_interp_if #(.DATA_WIDTH(32)) bus_b ();
  fir_interp_if #(.DATA_WIDTH(32)) bus_c ();

  fir_interp #(.INTERP(8), .TAPS(32), .DATA_WIDTH(32), .FRAC_BITS(10), .coeff(LPF)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_a)
  );
  fir_interp #(.INTERP(8), .TAPS(32), .DATA_WIDTH(32), .FRAC_BITS(10), .coeff(CSIGN)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_b)
  );
  fir_interp #(.INTERP(8), .TAPS(32), .DATA_WIDTH(32), .FRAC_BITS(10), .coeff(CWRAP)) u_dut_c (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_c)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr [3];
  logic [31:0]        inq  [3][$];
  logic [31:0]        expq [3][$];
  logic [31:0]        got  [3][$];
  logic signed [31:0] mh   [3][4];
  logic signed [31:0] ctab [3][32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference: phase p = sum_k floor(coeff[p+8k]*hist[k] / 2^10), truncated, wrapping sum.
  function automatic logic [31:0] model_phase(input int id, input int p);
    logic signed [63:0] pr;
    logic [31:0]        acc;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      pr  = $signed(ctab[id][p + 8 * k]) * $signed(mh[id][k]);
      acc = acc + 32'(pr >>> 10);
    end
    return acc;
  endfunction

  task automatic push(input int id, input logic [31:0] x);
    inq[id].push_back(x);
    for (int k = 3; k > 0; k--) mh[id][k] = mh[id][k-1];
    mh[id][0] = x;
    for (int p = 0; p < 8; p++) expq[id].push_back(model_phase(id, p));
  endtask

  task automatic mon(input int id, input logic we, input logic [31:0] y);
    logic [31:0] e;
    if (we) begin
      n_wr[id]++;
      got[id].push_back(y);
      if (expq[id].size() == 0) begin
        check($sformatf("unexpected_write_dut%0d", id), 32'd1, 32'd0);
      end else begin
        e = expq[id].pop_front();
        check($sformatf("y_dut%0d_n%0d", id, n_wr[id]), y, e);
      end
    end
  endtask

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    mon(0, bus_a.y_out_wr_en, bus_a.y_out);
    mon(1, bus_b.y_out_wr_en, bus_b.y_out);
    mon(2, bus_c.y_out_wr_en, bus_c.y_out);
  end

  // Show-ahead input FIFO models: pop on the strobe, then refresh head and empty.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus_a.x_in_rd_en) begin
        if (inq[0].size() == 0) check("pop_when_empty_dut0", 32'd1, 32'd0);
        else void'(inq[0].pop_front());
      end
      if (bus_b.x_in_rd_en) begin
        if (inq[1].size() == 0) check("pop_when_empty_dut1", 32'd1, 32'd0);
        else void'(inq[1].pop_front());
      end
      if (bus_c.x_in_rd_en) begin
        if (inq[2].size() == 0) check("pop_when_empty_dut2", 32'd1, 32'd0);
        else void'(inq[2].pop_front());
      end
    end
    #1;
    bus_a.x_in_empty = (inq[0].size() == 0);
    bus_a.x_in       = (inq[0].size() != 0) ? inq[0][0] : 32'd0;
    bus_b.x_in_empty = (inq[1].size() == 0);
    bus_b.x_in       = (inq[1].size() != 0) ? inq[1][0] : 32'd0;
    bus_c.x_in_empty = (inq[2].size() == 0);
    bus_c.x_in       = (inq[2].size() != 0) ? inq[2][0] : 32'd0;
  end

  task automatic clear_model();
    for (int id = 0; id < 3; id++) begin
      inq[id].delete();
      expq[id].delete();
      for (int k = 0; k < 4; k++) mh[id][k] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int id, input int budget, input string tag);
    int i;
    i = 0;
    while ((expq[id].size() != 0 || inq[id].size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check(tag, 32'(expq[id].size()), 32'd0);
  endtask

  task automatic wait_writes(input int id, input int target, input int budget);
    int i;
    i = 0;
    while (n_wr[id] < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_writes_timeout", 32'(n_wr[id] >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int bad;
    logic [31:0] snap;
    logic [31:0] v;

    for (int id = 0; id < 3; id++) n_wr[id] = 0;
    for (int i = 0; i < 32; i++) begin
      ctab[0][i] = LPF[i];
      ctab[1][i] = CSIGN[i];
      ctab[2][i] = CWRAP[i];
    end
    clear_model();
    bus_a.x_in_empty = 1'b1; bus_a.x_in = '0; bus_a.y_out_full = 1'b0;
    bus_b.x_in_empty = 1'b1; bus_b.x_in = '0; bus_b.y_out_full = 1'b0;
    bus_c.x_in_empty = 1'b1; bus_c.x_in = '0; bus_c.y_out_full = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_y_out", bus_a.y_out, 32'd0);
    check("rst_wr_en", 32'(bus_a.y_out_wr_en), 32'd0);
    check("rst_rd_en", 32'(bus_a.x_in_rd_en), 32'd0);
    rst = 1'b0;

    // 1: impulse reproduces the coefficient table
    base = n_wr[0];
    push(0, 32'd1024); push(0, 32'd0); push(0, 32'd0); push(0, 32'd0);
    drain(0, 400, "t1_drain");
    check("t1_count", 32'(n_wr[0] - base), 32'd32);
    v = got[0][base];
    check("t1_first", v, LPF[0]);

    // 2: DC input settles to the per-phase coefficient sums
    base = n_wr[0];
    for (int i = 0; i < 8; i++) push(0, 32'd1024);
    drain(0, 800, "t2_drain");
    check("t2_count", 32'(n_wr[0] - base), 32'd64);
    v = got[0][got[0].size() - 8];
    check("t2_dc_phase0", v, 32'd584);

    // 3: backpressure before the first write and again mid-sample
    do_reset();
    base = n_wr[0];
    bus_a.y_out_full = 1'b1;
    push(0, 32'd1024); push(0, 32'd0); push(0, 32'd0); push(0, 32'd0);
    bad = 0;
    snap = bus_a.y_out;
    repeat (25) begin
      @(negedge clk);
      if (bus_a.y_out_wr_en !== 1'b0) bad++;
      if (bus_a.y_out !== snap) bad++;
    end
    check("t3_hold_first", 32'(bad), 32'd0);
    bus_a.y_out_full = 1'b0;
    wait_writes(0, base + 10, 200);
    bus_a.y_out_full = 1'b1;
    bad = 0;
    snap = bus_a.y_out;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.y_out_wr_en !== 1'b0) bad++;
      if (bus_a.y_out !== snap) bad++;
    end
    check("t3_hold_mid", 32'(bad), 32'd0);
    check("t3_count_held", 32'(n_wr[0] - base), 32'd10);
    bus_a.y_out_full = 1'b0;
    drain(0, 400, "t3_drain");
    check("t3_count", 32'(n_wr[0] - base), 32'd32);

    // 4: starvation keeps both strobes low, then one sample gives 8 writes
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.x_in_rd_en !== 1'b0 || bus_a.y_out_wr_en !== 1'b0) bad++;
    end
    check("t4_idle", 32'(bad), 32'd0);
    base = n_wr[0];
    push(0, 32'd512);
    drain(0, 200, "t4_drain");
    check("t4_count", 32'(n_wr[0] - base), 32'd8);

    // 5: reset during phase 3 MAC drops the rest of the sample and clears history
    base = n_wr[0];
    push(0, 32'd1024);
    wait_writes(0, base + 3, 200);
    do_reset();
    repeat (40) @(negedge clk);
    check("t5_no_more_writes", 32'(n_wr[0] - base), 32'd3);
    check("t5_y_out_cleared", bus_a.y_out, 32'd0);
    base = n_wr[0];
    push(0, 32'd1024); push(0, 32'd0); push(0, 32'd0); push(0, 32'd0);
    drain(0, 400, "t5_drain");
    check("t5_count", 32'(n_wr[0] - base), 32'd32);
    v = got[0][base + 31];
    check("t5_last", v, LPF[31]);

    // 6: flooring of a negative product, then truncation and accumulator wrap
    base = n_wr[1];
    push(1, 32'hFFFF_FFFF);
    drain(1, 200, "t6_sign_drain");
    check("t6_sign_count", 32'(n_wr[1] - base), 32'd8);
    v = got[1][base];
    check("t6_floor_phase0", v, 32'hFFFF_FFFF);
    v = got[1][base + 1];
    check("t6_floor_phase1", v, 32'd0);
    base = n_wr[2];
    push(2, 32'h7FFF_FFFF); push(2, 32'h7FFF_FFFF);
    drain(2, 300, "t6_wrap_drain");
    check("t6_wrap_count", 32'(n_wr[2] - base), 32'd16);
    v = got[2][base];
    check("t6_trunc", v, 32'hFFFF_FFFE);
    v = got[2][base + 8];
    check("t6_wrap", v, 32'h7FFF_FFFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
